// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and helpers for the serial wide-add sequencer.
// Holds the FSM encoding, slice width and round-robin index step.
package cla_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned rr_next(
      input int unsigned idx,
      input int unsigned n
   );
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Client-side bundle of the shared adder sequencer.
// Requests and operands flow in; grant, completion and result flow out.
interface cla_add_sequencer_if #(
   parameter int NREQ  = 4,
   parameter int WORDS = 4
);
   localparam int W = WORDS * 16;

   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   sub;
   logic [NREQ*W-1:0] op_a;
   logic [NREQ*W-1:0] op_b;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      result;
   logic              cout;
   logic              ovf;
   logic [15:0]       skip_cnt;

   modport master (
      output req, sub, op_a, op_b,
      input  gnt, busy, done, result, cout, ovf, skip_cnt
   );

   modport slave (
      input  req, sub, op_a, op_b,
      output gnt, busy, done, result, cout, ovf, skip_cnt
   );

endinterface

// File: rtl/adder16.sv
// 16-bit carry-skip adder slice, four 4-bit blocks.
// Pout reports that every bit propagates, i.e. the carry fully skips.
module adder16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o,
   output logic        cout_o,
   output logic        pout_o
);

   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic [4:0]  bc;
   logic        rc;

   assign p      = a_i ^ b_i;
   assign g      = a_i & b_i;
   assign pout_o = &p;

   // Ripple inside each block; bypass the block when it fully propagates.
   always_comb begin
      c     = '0;
      bc    = '0;
      rc    = 1'b0;
      bc[0] = cin_i;
      for (int j = 0; j < 4; j++) begin
         rc = bc[j];
         for (int k = 0; k < 4; k++) begin
            c[j*4+k] = rc;
            rc = g[j*4+k] | (p[j*4+k] & rc);
         end
         bc[j+1] = (&p[j*4 +: 4]) ? bc[j] : rc;
      end
   end

   assign sum_o  = p ^ c;
   assign cout_o = bc[4];

endmodule

// File: rtl/cla_add_sequencer_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational pick, registered pointer.
// The pointer moves one past the winner whenever a grant is taken.
module rr_arbiter
   import cla_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o,
   output logic         any_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] idx;
   int            k;

   // First asserted request at or after the pointer, wrapping around.
   always_comb begin
      gnt_o = '0;
      idx   = '0;
      any_o = 1'b0;
      k     = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr_q) + i) % N;
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            idx      = IW'(k);
            gnt_o[k] = 1'b1;
         end
      end
   end

   // Advance the pointer past the winner on an accepted grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv_i && any_o) begin
         ptr_q <= IW'(rr_next(32'(idx), N));
      end
   end

endmodule

// File: rtl/cla_add_sequencer.sv
// Shares one adder16 between several wide add/subtract clients.
// Each granted request runs serially, one 16-bit slice per clock, LSB first.
module cla_add_sequencer
   import cla_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WORDS = 4
) (
   input logic                clk,
   input logic                rst_n,
   cla_add_sequencer_if.slave bus
);

   localparam int W  = WORDS * SLICE_W;
   localparam int CW = $clog2(WORDS) + 1;

   state_e         state_q;
   logic [NREQ-1:0] own_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic            busy_q;
   logic            sub_q;
   logic            carry_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    a_sh_q;
   logic [W-1:0]    b_sh_q;
   logic [W-1:0]    res_sh_q;
   logic [W-1:0]    res_sh_d;
   logic [W-1:0]    result_q;
   logic            cout_q;
   logic            ovf_q;
   logic [15:0]     skip_q;
   logic [15:0]     skip_d;

   logic [NREQ-1:0] arb_gnt;
   logic            arb_any;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic            sel_sub;

   logic [15:0]     add_a;
   logic [15:0]     add_b;
   logic [15:0]     sum;
   logic            add_co;
   logic            add_p;
   logic            c15;
   logic            last;

   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (bus.req),
      .adv_i (state_q == IDLE),
      .gnt_o (arb_gnt),
      .any_o (arb_any)
   );

   // Route the winner's operands and op select to the latch inputs.
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            sel_a   = bus.op_a[i*W +: W];
            sel_b   = bus.op_b[i*W +: W];
            sel_sub = bus.sub[i];
         end
      end
   end

   assign add_a = a_sh_q[SLICE_W-1:0];
   assign add_b = b_sh_q[SLICE_W-1:0] ^ {SLICE_W{sub_q}};

   adder16 u_add (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (carry_q),
      .sum_o  (sum),
      .cout_o (add_co),
      .pout_o (add_p)
   );

   assign c15    = add_a[15] ^ add_b[15] ^ sum[15];
   assign last   = (cnt_q == CW'(WORDS - 1));
   assign skip_d = (add_p && skip_q != 16'hFFFF) ? skip_q + 16'd1 : skip_q;

   if (WORDS == 1) begin : g_one
      assign res_sh_d = sum;
   end else begin : g_many
      assign res_sh_d = {sum, res_sh_q[W-1:SLICE_W]};
   end

   // Sequencer FSM with every output registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         own_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         skip_q   <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (arb_any) begin
                  state_q <= RUN;
                  own_q   <= arb_gnt;
                  gnt_q   <= arb_gnt;
                  busy_q  <= 1'b1;
                  a_sh_q  <= sel_a;
                  b_sh_q  <= sel_b;
                  sub_q   <= sel_sub;
                  carry_q <= sel_sub;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_sh_q   <= a_sh_q >> SLICE_W;
               b_sh_q   <= b_sh_q >> SLICE_W;
               res_sh_q <= res_sh_d;
               carry_q  <= add_co;
               skip_q   <= skip_d;
               cnt_q    <= cnt_q + CW'(1);
               if (last) begin
                  result_q <= res_sh_d;
                  cout_q   <= add_co;
                  ovf_q    <= c15 ^ add_co;
                  done_q   <= own_q;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.ovf      = ovf_q;
   assign bus.skip_cnt = skip_q;

endmodule
